nw_job_host: RTL and testbench
==============================

# nw_job_host

Synthesizable host-side memory responder and job sequencer for the Needleman-Wunsch kernel `workload_0`. It loads two 128-byte input sequences from a byte stream into local buffers, then starts the kernel through its ap_ctrl_hs handshake. While the kernel runs, it serves the kernel's SEQA/SEQB BRAM read ports and captures the alignedA/alignedB BRAM write ports. When the kernel finishes, it streams the two aligned results back out.

## Interface
Parameters:
- SEQ_LEN, 128: bytes per input sequence.
- ALN_LEN, 256: bytes per aligned output buffer.
- SA_W, 15: SEQA/SEQB address width.
- AL_W, 16: alignedA/alignedB address width.

Ports:
- ap_clk  in  1  single clock; all logic is rising-edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- in_valid / in_ready / in_data  in/out/in  1/1/8  load stream. Bytes 0..SEQ_LEN-1 go to SEQA; the next SEQ_LEN bytes go to SEQB.
- out_valid / out_ready / out_data  out/in/out  1/1/8  result stream. Bytes 0..ALN_LEN-1 come from alignedA; the next ALN_LEN bytes come from alignedB.
- k_ap_start  out  1  kernel start.
- k_ap_ready, k_ap_done, k_ap_idle  in  1  kernel handshake. k_ap_idle is status only and is not used for control.
- SEQA_ce0, SEQA_address0, SEQA_q0  in/in/out  1/SA_W/8  kernel read port A.
- SEQB_ce0, SEQB_address0, SEQB_q0  in/in/out  1/SA_W/8  kernel read port B.
- alignedA_ce0, alignedA_we0, alignedA_address0, alignedA_d0  in  1/1/AL_W/8  kernel write port A.
- alignedB_ce0, alignedB_we0, alignedB_address0, alignedB_d0  in  1/1/AL_W/8  kernel write port B.
- job_done  out  1  one-cycle pulse on the final output transfer.
- jobs_completed  out  16  count of completed jobs; wraps at 0xFFFF.

## Operation
FSM states and transitions:
- LOAD: reset state. in_ready=1. A byte is accepted on in_valid&&in_ready. After the 2*SEQ_LEN-th accept, go to CLEAR.
- CLEAR: lasts ALN_LEN cycles. Writes 0x00 to both aligned buffers at the index given by a counter. Then go to START.
- START: k_ap_start=1. On k_ap_ready=1, go to RUN. If k_ap_done=1 in the same cycle, go directly to DRAIN.
- RUN: k_ap_start=0. On k_ap_done=1, go to DRAIN.
- DRAIN: streams 2*ALN_LEN bytes. After the last transfer, pulse job_done, increment jobs_completed, and go to LOAD.

Kernel port rules:
- Reads: when SEQx_ce0=1, SEQx_q0 is registered with buf[address0] on the next edge. When ce0=0, q0 holds its value. Reads are served in every state.
- Out-of-range read (address0 ≥ SEQ_LEN): q0=0x00.
- Writes: when ce0&&we0 is high in START or RUN, the byte is stored. Writes are ignored in every other state. Writes to address0 ≥ ALN_LEN are dropped.
- SEQA, SEQB, alignedA and alignedB are independent single-port buffers, so simultaneous access on all four ports is legal.

## Timing
- Reset values: in_ready=1 (state LOAD), out_valid=0, out_data=0x00, k_ap_start=0, SEQA_q0=SEQB_q0=0x00, job_done=0, jobs_completed=0. Buffer contents are not reset.
- Read latency is exactly 1 cycle.
- in_ready drops in the cycle after the final load accept.
- k_ap_start is registered. It rises in the first START cycle, which is exactly ALN_LEN+1 cycles after the final load accept. It falls in the cycle after k_ap_ready is sampled high.
- DRAIN output:
  - out_valid rises within 2 cycles of entering DRAIN, using a one-deep prefetch register.
  - out_data and out_valid stay stable while out_valid&&!out_ready.
  - Sustained throughput is 1 byte/cycle when out_ready=1.
  - out_valid=0 in the cycle after the final transfer.
- Reset mid-operation: ap_rst_n low forces the reset values immediately. After release the block is in LOAD. Stale output bytes cannot leak into the next job because CLEAR always runs before START.

## Structure
- Package nw_host_pkg holds:
  - the state enum (LOAD, CLEAR, START, RUN, DRAIN);
  - the SEQ_LEN, ALN_LEN, SA_W and AL_W defaults;
  - the PAD byte constant 0x00.
- Sub-module nw_byte_ram: one per buffer, 4 instances. Single-port, registered read, synchronous write, depth parameter. Out-of-range access is handled by the parent.

## Test plan
Each scenario uses a behavioural kernel stub.
- Load and start: load 256 bytes where SEQA = "tcgacgaaat…cgccggc" and SEQB = "ttcgagggcg…ggtcgat". Expect in_ready=0 after the 256th accept, and k_ap_start=1 exactly 257 cycles after that accept edge.
- Reads: SEQA_ce0=1 at address 0 gives q0=0x74 ('t') one cycle later. SEQA address 127 gives 0x63. SEQB address 0 gives 0x74. SEQA address 200 gives 0x00. With ce0=0, q0 holds its last value.
- Writes and drain: stub writes alignedA[0]=0x2D, alignedA[255]=0x41, alignedB[3]=0x67, then asserts done. Drained stream must be: byte0=0x2D, byte255=0x41, byte259=0x67, all others 0x00, 512 bytes total, with one job_done pulse and jobs_completed=1.
- Back-pressure: with out_ready toggling 1,0,0,1 repeatedly, expect exactly 512 transfers, no duplicates or drops, and out_data stable across stall cycles.
- Coincident handshake: k_ap_ready and k_ap_done high in the same START cycle. Expect the FSM to enter DRAIN, k_ap_start=0 on the next cycle, and writes after done to be ignored.
- Reset mid-RUN: pull ap_rst_n low during RUN. Expect all outputs at reset values. A following full job (different data) drains only the new writes, with unwritten bytes at 0x00.

Source files
------------

// File: rtl/nw_host_pkg.sv
// Shared types and defaults for the Needleman-Wunsch host responder.
// Buffer sizes are assumed to be powers of two.
package nw_host_pkg;

    localparam int SEQ_LEN_DEF = 128;
    localparam int ALN_LEN_DEF = 256;
    localparam int SA_W_DEF    = 15;
    localparam int AL_W_DEF    = 16;

    localparam logic [7:0] PAD = 8'h00;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } nw_state_e;

    // Debug view: sequencer state plus the kernel's idle status.
    typedef struct packed {
        nw_state_e state;
        logic      k_idle;
    } nw_dbg_t;

endpackage

// File: rtl/nw_byte_ram.sv
// Byte buffer with synchronous write and registered read.
// Contents are never reset; only the read register is.
module nw_byte_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Holds its value while i_re is low; the parent relies on this.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= 8'h00;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/nw_job_host.sv
// Host-side job sequencer for the NW kernel: loads SEQA/SEQB, clears the
// aligned buffers, runs the ap_ctrl_hs handshake, then drains alignedA/alignedB.
module nw_job_host
    import nw_host_pkg::*;
#(
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter int ALN_LEN = ALN_LEN_DEF,
    parameter int SA_W    = SA_W_DEF,
    parameter int AL_W    = AL_W_DEF
) (
    input  logic            ap_clk,
    input  logic            ap_rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            k_ap_start,
    input  logic            k_ap_ready,
    input  logic            k_ap_done,
    input  logic            k_ap_idle,
    input  logic            SEQA_ce0,
    input  logic [SA_W-1:0] SEQA_address0,
    output logic [7:0]      SEQA_q0,
    input  logic            SEQB_ce0,
    input  logic [SA_W-1:0] SEQB_address0,
    output logic [7:0]      SEQB_q0,
    input  logic            alignedA_ce0,
    input  logic            alignedA_we0,
    input  logic [AL_W-1:0] alignedA_address0,
    input  logic [7:0]      alignedA_d0,
    input  logic            alignedB_ce0,
    input  logic            alignedB_we0,
    input  logic [AL_W-1:0] alignedB_address0,
    input  logic [7:0]      alignedB_d0,
    output logic            job_done,
    output logic [15:0]     jobs_completed,
    output nw_dbg_t         o_dbg
);

    localparam int SAI     = $clog2(SEQ_LEN);
    localparam int ALI     = $clog2(ALN_LEN);
    localparam int CNT_MAX = (2 * SEQ_LEN > ALN_LEN) ? 2 * SEQ_LEN : ALN_LEN;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int DW      = $clog2(2 * ALN_LEN) + 1;

    nw_state_e       r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_k_start;
    logic [15:0]     r_jobs;
    logic [DW-1:0]   r_rd_idx;
    logic [DW-1:0]   r_out_cnt;
    logic            r_pend;
    logic            r_pend_sel;
    logic            r_out_valid;
    logic [7:0]      r_out_data;
    logic            r_sa_oor;
    logic            r_sb_oor;

    logic            w_acc;
    logic            w_clear;
    logic            w_kwin;
    logic            w_sa_inr, w_sb_inr;
    logic            w_ala_inr, w_alb_inr;
    logic            w_ala_we, w_alb_we;
    logic [ALI-1:0]  w_ala_waddr, w_alb_waddr;
    logic [7:0]      w_ala_wdata, w_alb_wdata;
    logic [7:0]      w_sa_q, w_sb_q, w_ala_q, w_alb_q;
    logic            w_load_out;
    logic            w_issue;
    logic            w_xfer;
    logic            w_last;
    logic [7:0]      w_pend_data;

    assign in_ready = (r_state == ST_LOAD);
    assign w_acc    = in_valid && in_ready;
    assign w_clear  = (r_state == ST_CLEAR);
    assign w_kwin   = (r_state == ST_START) || (r_state == ST_RUN);

    // Load bytes: the top counter bit selects SEQB, the low bits index either buffer.
    nw_byte_ram #(.DEPTH(SEQ_LEN)) u_seqa (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_we    (w_acc && !r_cnt[SAI]),
        .i_waddr (r_cnt[SAI-1:0]),
        .i_wdata (in_data),
        .i_re    (SEQA_ce0 && w_sa_inr),
        .i_raddr (SEQA_address0[SAI-1:0]),
        .o_rdata (w_sa_q)
    );

    nw_byte_ram #(.DEPTH(SEQ_LEN)) u_seqb (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_we    (w_acc && r_cnt[SAI]),
        .i_waddr (r_cnt[SAI-1:0]),
        .i_wdata (in_data),
        .i_re    (SEQB_ce0 && w_sb_inr),
        .i_raddr (SEQB_address0[SAI-1:0]),
        .o_rdata (w_sb_q)
    );

    assign w_sa_inr = (SEQA_address0 < SA_W'(SEQ_LEN));
    assign w_sb_inr = (SEQB_address0 < SA_W'(SEQ_LEN));

    // An out-of-range read leaves the RAM register alone and forces PAD instead.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_sa_oor <= 1'b0;
            r_sb_oor <= 1'b0;
        end else begin
            if (SEQA_ce0) r_sa_oor <= !w_sa_inr;
            if (SEQB_ce0) r_sb_oor <= !w_sb_inr;
        end
    end

    assign SEQA_q0 = r_sa_oor ? PAD : w_sa_q;
    assign SEQB_q0 = r_sb_oor ? PAD : w_sb_q;

    assign w_ala_inr   = (alignedA_address0 < AL_W'(ALN_LEN));
    assign w_alb_inr   = (alignedB_address0 < AL_W'(ALN_LEN));
    assign w_ala_we    = w_clear || (w_kwin && alignedA_ce0 && alignedA_we0 && w_ala_inr);
    assign w_alb_we    = w_clear || (w_kwin && alignedB_ce0 && alignedB_we0 && w_alb_inr);
    assign w_ala_waddr = w_clear ? r_cnt[ALI-1:0] : alignedA_address0[ALI-1:0];
    assign w_alb_waddr = w_clear ? r_cnt[ALI-1:0] : alignedB_address0[ALI-1:0];
    assign w_ala_wdata = w_clear ? PAD : alignedA_d0;
    assign w_alb_wdata = w_clear ? PAD : alignedB_d0;

    nw_byte_ram #(.DEPTH(ALN_LEN)) u_ala (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_we    (w_ala_we),
        .i_waddr (w_ala_waddr),
        .i_wdata (w_ala_wdata),
        .i_re    (w_issue && !r_rd_idx[ALI]),
        .i_raddr (r_rd_idx[ALI-1:0]),
        .o_rdata (w_ala_q)
    );

    nw_byte_ram #(.DEPTH(ALN_LEN)) u_alb (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_we    (w_alb_we),
        .i_waddr (w_alb_waddr),
        .i_wdata (w_alb_wdata),
        .i_re    (w_issue && r_rd_idx[ALI]),
        .i_raddr (r_rd_idx[ALI-1:0]),
        .o_rdata (w_alb_q)
    );

    // The RAM read register is the one-deep prefetch stage in front of out_data.
    assign w_pend_data = r_pend_sel ? w_alb_q : w_ala_q;
    assign w_xfer      = r_out_valid && out_ready;
    assign w_load_out  = r_pend && (!r_out_valid || out_ready);
    assign w_issue     = (r_state == ST_DRAIN) && (r_rd_idx != DW'(2 * ALN_LEN))
                         && (!r_pend || w_load_out);
    assign w_last      = w_xfer && (r_out_cnt == DW'(2 * ALN_LEN - 1));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= ST_LOAD;
            r_cnt       <= '0;
            r_k_start   <= 1'b0;
            r_jobs      <= 16'h0000;
            r_rd_idx    <= '0;
            r_out_cnt   <= '0;
            r_pend      <= 1'b0;
            r_pend_sel  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= PAD;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_acc) begin
                        if (r_cnt == CW'(2 * SEQ_LEN - 1)) begin
                            r_cnt   <= '0;
                            r_state <= ST_CLEAR;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == CW'(ALN_LEN - 1)) begin
                        r_cnt     <= '0;
                        r_state   <= ST_START;
                        r_k_start <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_START: begin
                    if (k_ap_ready) begin
                        r_k_start <= 1'b0;
                        r_state   <= k_ap_done ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (k_ap_done) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_issue) begin
                        r_rd_idx   <= r_rd_idx + 1'b1;
                        r_pend_sel <= r_rd_idx[ALI];
                    end
                    r_pend <= w_issue || (r_pend && !w_load_out);
                    if (w_load_out) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_pend_data;
                    end else if (w_xfer) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_xfer) r_out_cnt <= r_out_cnt + 1'b1;
                    if (w_last) begin
                        r_state   <= ST_LOAD;
                        r_jobs    <= r_jobs + 16'h0001;
                        r_rd_idx  <= '0;
                        r_out_cnt <= '0;
                        r_pend    <= 1'b0;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign k_ap_start     = r_k_start;
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign job_done       = w_last;
    assign jobs_completed = r_jobs;
    assign o_dbg.state    = r_state;
    assign o_dbg.k_idle   = k_ap_idle;

endmodule

// File: tb/tb_nw_job_host.sv
// Self-checking bench for nw_job_host: behavioural kernel stub, array model of
// the four buffers, and a byte scoreboard for the drained result stream.
module tb_nw_job_host;
    import nw_host_pkg::*;

    localparam int SEQ_LEN = SEQ_LEN_DEF;
    localparam int ALN_LEN = ALN_LEN_DEF;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        k_ap_start;
    logic        k_ap_ready = 1'b0;
    logic        k_ap_done = 1'b0;
    logic        k_ap_idle = 1'b1;
    logic        SEQA_ce0 = 1'b0;
    logic [14:0] SEQA_address0 = '0;
    logic [7:0]  SEQA_q0;
    logic        SEQB_ce0 = 1'b0;
    logic [14:0] SEQB_address0 = '0;
    logic [7:0]  SEQB_q0;
    logic        alignedA_ce0 = 1'b0, alignedA_we0 = 1'b0;
    logic [15:0] alignedA_address0 = '0;
    logic [7:0]  alignedA_d0 = 8'h00;
    logic        alignedB_ce0 = 1'b0, alignedB_we0 = 1'b0;
    logic [15:0] alignedB_address0 = '0;
    logic [7:0]  alignedB_d0 = 8'h00;
    logic        job_done;
    logic [15:0] jobs_completed;
    nw_dbg_t     o_dbg;

    nw_job_host dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .k_ap_start(k_ap_start), .k_ap_ready(k_ap_ready), .k_ap_done(k_ap_done), .k_ap_idle(k_ap_idle),
        .SEQA_ce0(SEQA_ce0), .SEQA_address0(SEQA_address0), .SEQA_q0(SEQA_q0),
        .SEQB_ce0(SEQB_ce0), .SEQB_address0(SEQB_address0), .SEQB_q0(SEQB_q0),
        .alignedA_ce0(alignedA_ce0), .alignedA_we0(alignedA_we0),
        .alignedA_address0(alignedA_address0), .alignedA_d0(alignedA_d0),
        .alignedB_ce0(alignedB_ce0), .alignedB_we0(alignedB_we0),
        .alignedB_address0(alignedB_address0), .alignedB_d0(alignedB_d0),
        .job_done(job_done), .jobs_completed(jobs_completed), .o_dbg(o_dbg)
    );

    // Clock / reset
    always #5 ap_clk = ~ap_clk;

    // Model and scoreboard
    logic [7:0]  m_sa [SEQ_LEN];
    logic [7:0]  m_sb [SEQ_LEN];
    logic [7:0]  m_aa [ALN_LEN];
    logic [7:0]  m_ab [ALN_LEN];
    logic [7:0]  exp_q[$];
    int          exp_jobs = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        bit          port_b;
        logic [14:0] addr;
        bit          ce;
        logic [7:0]  exp;
        string       name;
    } rd_vec_t;
    rd_vec_t rd_tab[11];

    task automatic cyc();
        @(negedge ap_clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        #1;
        check({tag, "_in_ready"},   32'(in_ready), 1);
        check({tag, "_out_valid"},  32'(out_valid), 0);
        check({tag, "_out_data"},   32'(out_data), 0);
        check({tag, "_k_start"},    32'(k_ap_start), 0);
        check({tag, "_seqa_q0"},    32'(SEQA_q0), 0);
        check({tag, "_seqb_q0"},    32'(SEQB_q0), 0);
        check({tag, "_job_done"},   32'(job_done), 0);
        check({tag, "_jobs_count"}, 32'(jobs_completed), 0);
    endtask

    task automatic make_seqs(input bit fixed);
        string alpha = "acgt";
        string pa = "tcgacgaaat";
        string sa = "cgccggc";
        string pb = "ttcgagggcg";
        string sb = "ggtcgat";
        for (int i = 0; i < SEQ_LEN; i++) begin
            m_sa[i] = alpha[$urandom_range(0, 3)];
            m_sb[i] = alpha[$urandom_range(0, 3)];
        end
        if (fixed) begin
            for (int i = 0; i < pa.len(); i++) m_sa[i] = pa[i];
            for (int i = 0; i < sa.len(); i++) m_sa[SEQ_LEN - sa.len() + i] = sa[i];
            for (int i = 0; i < pb.len(); i++) m_sb[i] = pb[i];
            for (int i = 0; i < sb.len(); i++) m_sb[SEQ_LEN - sb.len() + i] = sb[i];
        end
        // CLEAR zeroes both result buffers before every run
        for (int i = 0; i < ALN_LEN; i++) begin
            m_aa[i] = 8'h00;
            m_ab[i] = 8'h00;
        end
    endtask

    task automatic build_exp();
        exp_q.delete();
        for (int i = 0; i < ALN_LEN; i++) exp_q.push_back(m_aa[i]);
        for (int i = 0; i < ALN_LEN; i++) exp_q.push_back(m_ab[i]);
    endtask

    // Driver: load stream with random gaps; returns at the negedge after the final accept.
    task automatic load_job(input string name);
        int idx = 0;
        int guard = 0;
        bit rdy_ok = 1;
        while (idx < 2 * SEQ_LEN && guard < 4000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = (idx < SEQ_LEN) ? m_sa[idx] : m_sb[idx - SEQ_LEN];
            if (in_ready !== 1'b1) rdy_ok = 0;
            cyc();
            if (in_valid && rdy_ok) idx++;
            guard++;
        end
        check({name, "_in_ready_during_load"}, 32'(rdy_ok), 1);
        check({name, "_in_ready_drop"}, 32'(in_ready), 0);
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (k_ap_start !== 1'b1 && n < 1000) begin
            cyc();
            n++;
        end
        check({name, "_start_seen"}, 32'(k_ap_start), 1);
    endtask

    task automatic kready(input string name);
        k_ap_ready = 1'b1;
        k_ap_idle  = 1'b0;
        cyc();
        k_ap_ready = 1'b0;
        check({name, "_start_fall"}, 32'(k_ap_start), 0);
    endtask

    task automatic kdone();
        k_ap_done = 1'b1;
        cyc();
        k_ap_done = 1'b0;
        k_ap_idle = 1'b1;
    endtask

    task automatic kwrite(input bit a_en, input int a_addr, input logic [7:0] a_d,
                          input bit b_en, input int b_addr, input logic [7:0] b_d,
                          input bit store);
        alignedA_ce0 = a_en; alignedA_we0 = a_en;
        alignedA_address0 = 16'(a_addr); alignedA_d0 = a_d;
        alignedB_ce0 = b_en; alignedB_we0 = b_en;
        alignedB_address0 = 16'(b_addr); alignedB_d0 = b_d;
        cyc();
        alignedA_ce0 = 1'b0; alignedA_we0 = 1'b0;
        alignedB_ce0 = 1'b0; alignedB_we0 = 1'b0;
        if (store && a_en && a_addr < ALN_LEN) m_aa[a_addr] = a_d;
        if (store && b_en && b_addr < ALN_LEN) m_ab[b_addr] = b_d;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic drain(input int mode, input bit check_lat, input string name);
        int cyc_n = 0;
        int xfers = 0;
        int first_v = -1;
        int gaps = 0;
        int pulses = 0;
        bit stalled = 0;
        logic [7:0] held = 8'h00;
        logic [7:0] exp_b;
        while (xfers < 2 * ALN_LEN && cyc_n < 4000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc_n % 4) == 0) || ((cyc_n % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (stalled)
                check($sformatf("%s_stall_hold", name), 32'({out_valid, out_data}), 32'({1'b1, held}));
            if (out_valid === 1'b1 && first_v < 0) first_v = cyc_n;
            if (job_done === 1'b1) pulses++;
            if (out_valid === 1'b1 && out_ready) begin
                exp_b = exp_q.pop_front();
                check($sformatf("%s_byte%0d", name, xfers), 32'(out_data), 32'(exp_b));
                if (xfers == 2 * ALN_LEN - 1) check({name, "_job_done_last"}, 32'(job_done), 1);
                xfers++;
                stalled = 0;
            end else begin
                stalled = (out_valid === 1'b1);
                held = out_data;
                if (first_v >= 0 && out_ready) gaps++;
            end
            cyc();
            cyc_n++;
        end
        out_ready = 1'b0;
        check({name, "_xfer_count"}, 32'(xfers), 2 * ALN_LEN);
        check({name, "_valid_after_last"}, 32'(out_valid), 0);
        check({name, "_done_pulses"}, 32'(pulses), 1);
        check({name, "_jobs_completed"}, 32'(jobs_completed), 32'(exp_jobs));
        if (check_lat) check({name, "_first_valid_le2"}, 32'(first_v >= 0 && first_v <= 2), 1);
        if (mode == 0) check({name, "_no_bubbles"}, 32'(gaps), 0);
    endtask

    task automatic fill_rd_tab();
        rd_tab[0]  = '{0, 15'd0,      1, 8'h74,           "rd_a0"};
        rd_tab[1]  = '{0, 15'd127,    1, 8'h63,           "rd_a127"};
        rd_tab[2]  = '{1, 15'd0,      1, 8'h74,           "rd_b0"};
        rd_tab[3]  = '{0, 15'd200,    1, 8'h00,           "rd_a200_oor"};
        rd_tab[4]  = '{0, 15'd5,      0, 8'h00,           "rd_a_hold_pad"};
        rd_tab[5]  = '{0, 15'd1,      1, m_sa[1],         "rd_a1"};
        rd_tab[6]  = '{0, 15'd7,      0, m_sa[1],         "rd_a_hold"};
        rd_tab[7]  = '{1, 15'd127,    1, 8'h74,           "rd_b127"};
        rd_tab[8]  = '{1, 15'h7FFF,   1, 8'h00,           "rd_b_max_oor"};
        rd_tab[9]  = '{1, 15'd64,     1, m_sb[64],        "rd_b64"};
        rd_tab[10] = '{0, 15'd64,     1, m_sa[64],        "rd_a64"};
    endtask

    task automatic job1();
        bit early = 0;
        make_seqs(1);
        load_job("job1");
        // Final accept was in cycle 0; CLEAR fills cycles 1..256; START begins in cycle 257.
        for (int n = 1; n <= 256; n++) begin
            if (k_ap_start !== 1'b0) early = 1;
            cyc();
        end
        check("job1_k_start_early", 32'(early), 0);
        check("job1_k_start_cycle257", 32'(k_ap_start), 1);
        kready("job1");
        fill_rd_tab();
        foreach (rd_tab[i]) begin
            if (rd_tab[i].port_b) begin
                SEQB_ce0 = rd_tab[i].ce; SEQB_address0 = rd_tab[i].addr;
            end else begin
                SEQA_ce0 = rd_tab[i].ce; SEQA_address0 = rd_tab[i].addr;
            end
            cyc();
            SEQA_ce0 = 1'b0; SEQB_ce0 = 1'b0;
            check(rd_tab[i].name, 32'(rd_tab[i].port_b ? SEQB_q0 : SEQA_q0), 32'(rd_tab[i].exp));
        end
        kwrite(1, 0, 8'h2D, 1, 3, 8'h67, 1);
        kwrite(1, 255, 8'h41, 0, 0, 8'h00, 1);
        kwrite(1, 256, 8'hEE, 1, 16'hFFFF, 8'hEE, 1);
        kdone();
        build_exp();
        exp_jobs++;
        drain(0, 1, "job1");
    endtask

    task automatic job2();
        make_seqs(0);
        load_job("job2");
        wait_start("job2");
        k_ap_ready = 1'b1;
        k_ap_done  = 1'b1;
        cyc();
        k_ap_ready = 1'b0;
        k_ap_done  = 1'b0;
        check("job2_coincident_start_low", 32'(k_ap_start), 0);
        check("job2_coincident_state", 32'(o_dbg.state), 32'(ST_DRAIN));
        build_exp();
        exp_jobs++;
        kwrite(1, 200, 8'h55, 1, 201, 8'h66, 0);
        drain(1, 0, "job2");
    endtask

    task automatic job3_reset();
        make_seqs(0);
        load_job("job3");
        wait_start("job3");
        kready("job3");
        for (int i = 0; i < 8; i++)
            kwrite(1, $urandom_range(0, 255), 8'($urandom_range(1, 255)),
                   1, $urandom_range(0, 255), 8'($urandom_range(1, 255)), 1);
        SEQA_ce0 = 1'b1; SEQA_address0 = 15'd0; SEQB_ce0 = 1'b1; SEQB_address0 = 15'd0;
        cyc();
        SEQA_ce0 = 1'b0; SEQB_ce0 = 1'b0;
        check("job3_pre_reset_state", 32'(o_dbg.state), 32'(ST_RUN));
        ap_rst_n = 1'b0;
        check_reset("midrun");
        cyc();
        ap_rst_n = 1'b1;
        k_ap_idle = 1'b1;
        exp_jobs = 0;
    endtask

    task automatic job4();
        int ra, rb;
        make_seqs(0);
        load_job("job4");
        wait_start("job4");
        kwrite(1, 10, 8'h5A, 1, 20, 8'hA5, 1);
        kready("job4");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                ra = $urandom_range(0, 199);
                rb = $urandom_range(0, 199);
                SEQA_ce0 = 1'b1; SEQA_address0 = 15'(ra);
                SEQB_ce0 = 1'b1; SEQB_address0 = 15'(rb);
                cyc();
                SEQA_ce0 = 1'b0; SEQB_ce0 = 1'b0;
                check("job4_rand_rd_a", 32'(SEQA_q0), 32'((ra < SEQ_LEN) ? m_sa[ra] : 8'h00));
                check("job4_rand_rd_b", 32'(SEQB_q0), 32'((rb < SEQ_LEN) ? m_sb[rb] : 8'h00));
            end else begin
                kwrite(1'($urandom_range(0, 1)), $urandom_range(0, 299), 8'($urandom_range(1, 255)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 299), 8'($urandom_range(1, 255)), 1);
            end
        end
        kdone();
        build_exp();
        exp_jobs++;
        drain(2, 1, "job4");
    endtask

    initial begin
        ap_rst_n = 1'b0;
        repeat (3) cyc();
        check_reset("por");
        check("por_state", 32'(o_dbg.state), 32'(ST_LOAD));
        cyc();
        ap_rst_n = 1'b1;
        job1();
        job2();
        job3_reset();
        job4();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
